// File: rtl/obi_mem_sbr.sv
// OBI subordinate terminating one manager port with a word-addressed on-chip memory.
// Build option OBI_MEM_SBR_RREADY_EN: honour rready_i via a response FIFO and an outstanding-transaction bound.
module obi_mem_sbr #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned IdWidth     = 1,
    parameter int unsigned NumWords    = 256,
    parameter int unsigned Latency     = 1,
    parameter int unsigned NumMaxTrans = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o
);
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned AddrLsb  = $clog2(NumBytes);
    localparam int unsigned IdxWidth = $clog2(NumWords);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 err;
    } resp_t;

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [IdxWidth-1:0]  idx;
    logic                 in_range;
    logic                 accept;
    logic                 active_q;
    resp_t                a_resp;
    logic [Latency-1:0]   pv_q;
    resp_t                pd_q [Latency];
    logic                 pipe_v;
    resp_t                pipe_r;
    logic                 out_v;
    resp_t                out_r;

    assign idx      = addr_i[AddrLsb +: IdxWidth];
    assign in_range = ({1'b0, addr_i} < (AddrWidth + 1)'(NumWords * NumBytes));
    assign accept   = req_i & gnt_o;

    always_comb begin
        a_resp     = '0;
        a_resp.id  = aid_i;
        a_resp.err = !in_range;
        if (in_range && !we_i) begin
            a_resp.data = mem_q[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // active_q keeps gnt_o low through the reset cycles without a path from rst_ni.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            pv_q     <= '0;
        end else begin
            active_q <= 1'b1;
            pv_q[0]  <= accept;
            for (int unsigned i = 1; i < Latency; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        pd_q[0] <= a_resp;
        for (int unsigned i = 1; i < Latency; i++) begin
            pd_q[i] <= pd_q[i-1];
        end
    end

    assign pipe_v = pv_q[Latency-1];
    assign pipe_r = pd_q[Latency-1];

`ifdef OBI_MEM_SBR_RREADY_EN
    localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
    localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumMaxTrans);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumMaxTrans - 1);

    resp_t               fifo_q [NumMaxTrans];
    logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntWidth-1:0] fcnt_q, fcnt_d, cnt_q, cnt_d;
    logic                fifo_empty, push, pop, r_ack;

    assign fifo_empty = (fcnt_q == '0);
    assign out_v      = pipe_v | !fifo_empty;
    assign out_r      = fifo_empty ? pipe_r : fifo_q[rptr_q];
    assign r_ack      = out_v & rready_i;
    // An accepted response leaving the pipeline into an empty FIFO bypasses storage.
    assign push       = pipe_v & !(fifo_empty & rready_i);
    assign pop        = !fifo_empty & rready_i;
    assign gnt_o      = active_q & (cnt_q != MaxCnt);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
        if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CntWidth'(1);
            2'b01:   fcnt_d = fcnt_q - CntWidth'(1);
            default: fcnt_d = fcnt_q;
        endcase
        case ({accept, r_ack})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= pipe_r;
    end
`else
    logic unused_rready;
    assign unused_rready = rready_i;
    assign out_v         = pipe_v;
    assign out_r         = pipe_r;
    assign gnt_o         = active_q;
`endif

    assign rvalid_o = out_v;
    assign rdata_o  = out_v ? out_r.data : '0;
    assign rid_o    = out_v ? out_r.id : '0;
    assign err_o    = out_v & out_r.err;
endmodule
